int_ctl: RTL and testbench

Interrupt front end for the 65C02 core. Synchronises the asynchronous `IRQ_n`/`NMI_n` pins, edge-detects and latches NMI, and generates the post-reset start request. It drives the `irq`/`nmi` request inputs of the microcode controller and clears latched requests when the controller accepts them on a `sync` cycle. It also supplies the low byte of the vector address (FA/FC/FE) to the address-bus logic and a `wake` signal for WAI.

---
 rtl/int_ctl.sv | 104 ++++++++++
 tb/tb_int_ctl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/int_ctl.sv
// Interrupt front end for the 65C02 core: pin synchronisers, NMI edge latch,
// post-reset start request, vector low byte and WAI wake.

module int_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    // Reset to the inactive (high) pin level so nothing fires out of reset.
    always_ff @(posedge clk) begin
        if (!reset) chain <= '1;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];
endmodule

module int_ctl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       IRQ_n,
    input  logic       NMI_n,
    input  logic       sync,
    input  logic       I,
    output logic       irq,
    output logic       nmi,
    output logic [7:0] vector,
    output logic       wake
);
    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] VEC_RST = 8'hFC;
    localparam logic [7:0] VEC_IRQ = 8'hFE;

    logic                 irq_s;
    logic                 nmi_s;
    logic                 nmi_d;
    logic                 nmi_pend;
    logic                 rst_pend;
    logic [SYNC_STAGES:0] vld_pipe;
    logic                 fall;
    logic                 ack;

    int_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .d     (IRQ_n),
        .q     (irq_s)
    );

    int_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk   (clk),
        .reset (reset),
        .d     (NMI_n),
        .q     (nmi_s)
    );

    assign irq = ~irq_s;
    assign nmi = nmi_pend | rst_pend;
    assign ack = sync & (nmi | (irq & ~I));

    // vld_pipe tracks which synchroniser stages (and nmi_d) hold real pin
    // samples rather than reset fill, so a pin held low across reset release
    // is not mistaken for a falling edge.
    assign fall = vld_pipe[SYNC_STAGES] & nmi_d & ~nmi_s;

    always_ff @(posedge clk) begin
        if (!reset) begin
            nmi_d    <= 1'b1;
            vld_pipe <= '0;
            nmi_pend <= 1'b0;
            rst_pend <= 1'b1;
            vector   <= VEC_RST;
            wake     <= 1'b0;
        end else begin
            nmi_d    <= nmi_s;
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
            wake     <= irq | nmi_pend | rst_pend;

            // A fresh edge always wins over a clear in the same cycle; the
            // reset start request is served first and leaves NMI pending.
            nmi_pend <= fall | (nmi_pend & ~(ack & ~rst_pend));

            if (ack) begin
                if (rst_pend) begin
                    rst_pend <= 1'b0;
                    vector   <= VEC_RST;
                end else if (nmi_pend) begin
                    vector   <= VEC_NMI;
                end else begin
                    vector   <= VEC_IRQ;
                end
            end else if (sync) begin
                vector <= VEC_IRQ;
            end
        end
    end
endmodule

// File: tb/tb_int_ctl.sv
// Self-checking bench for int_ctl: cycle table of inputs and expected outputs,
// expectations queued on drive and compared one clock later.

module tb_int_ctl;
    logic       clk = 1'b0;
    logic       reset;
    logic       IRQ_n;
    logic       NMI_n;
    logic       sync;
    logic       I;
    logic       irq;
    logic       nmi;
    logic [7:0] vector;
    logic       wake;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rs;
        logic       irq_n;
        logic       nmi_n;
        logic       sy;
        logic       i;
        logic       e_irq;
        logic       e_nmi;
        logic [7:0] e_vec;
        logic       e_wake;
        int         id;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    int_ctl #(.SYNC_STAGES(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .IRQ_n  (IRQ_n),
        .NMI_n  (NMI_n),
        .sync   (sync),
        .I      (I),
        .irq    (irq),
        .nmi    (nmi),
        .vector (vector),
        .wake   (wake)
    );

    always #5 clk = ~clk;

    task automatic r(input logic rs, input logic in_, input logic nn, input logic sy,
                     input logic ii, input logic ei, input logic en,
                     input logic [7:0] ev, input logic ew);
        vec_t v;
        v.rs = rs; v.irq_n = in_; v.nmi_n = nn; v.sy = sy; v.i = ii;
        v.e_irq = ei; v.e_nmi = en; v.e_vec = ev; v.e_wake = ew;
        v.id = tbl.size();
        tbl.push_back(v);
    endtask

    task automatic chk1(input string name, input int id, input logic [7:0] got,
                        input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, id, got, exp);
        end
    endtask

    initial begin
        vec_t cur;
        vec_t e;
        reset = 1'b0; IRQ_n = 1'b1; NMI_n = 1'b1; sync = 1'b0; I = 1'b1;

        //  rs irqn nmin sync I | irq nmi vec wake
        // reset held 3 clocks, then start request accepted with FC
        r(0,1,1,0,1, 0,1,8'hFC,0);
        r(0,1,1,0,1, 0,1,8'hFC,0);
        r(0,1,1,0,1, 0,1,8'hFC,0);
        r(1,1,1,1,1, 0,0,8'hFC,1);
        r(1,1,1,0,1, 0,0,8'hFC,0);
        r(1,1,1,1,1, 0,0,8'hFE,0);
        r(1,1,1,0,1, 0,0,8'hFE,0);
        // NMI fall: nmi after 3 clocks, accepted with FA, no re-trigger while low
        r(1,1,0,0,1, 0,0,8'hFE,0);
        r(1,1,0,0,1, 0,0,8'hFE,0);
        r(1,1,0,0,1, 0,1,8'hFE,0);
        r(1,1,0,0,1, 0,1,8'hFE,1);
        r(1,1,0,1,1, 0,0,8'hFA,1);
        r(1,1,0,0,1, 0,0,8'hFA,0);
        r(1,1,0,1,1, 0,0,8'hFE,0);
        // IRQ level, masked then unmasked, then released
        r(1,0,0,0,1, 0,0,8'hFE,0);
        r(1,0,0,1,1, 1,0,8'hFE,0);
        r(1,0,0,1,1, 1,0,8'hFE,1);
        r(1,0,0,1,0, 1,0,8'hFE,1);
        r(1,1,0,0,1, 1,0,8'hFE,1);
        r(1,1,0,0,1, 0,0,8'hFE,1);
        r(1,1,0,0,1, 0,0,8'hFE,0);
        // coincident: second NMI edge detected on the ack cycle of the first
        r(1,1,1,0,1, 0,0,8'hFE,0);
        r(1,1,1,0,1, 0,0,8'hFE,0);
        r(1,1,1,0,1, 0,0,8'hFE,0);
        r(1,1,0,0,1, 0,0,8'hFE,0);
        r(1,1,0,0,1, 0,0,8'hFE,0);
        r(1,1,0,0,1, 0,1,8'hFE,0);
        r(1,1,1,0,1, 0,1,8'hFE,1);
        r(1,1,1,0,1, 0,1,8'hFE,1);
        r(1,1,1,0,1, 0,1,8'hFE,1);
        r(1,1,0,0,1, 0,1,8'hFE,1);
        r(1,1,0,0,1, 0,1,8'hFE,1);
        r(1,1,0,1,1, 0,1,8'hFA,1);
        r(1,1,0,0,1, 0,1,8'hFA,1);
        r(1,1,0,1,1, 0,0,8'hFA,1);
        r(1,1,0,0,1, 0,0,8'hFA,0);
        r(1,1,0,1,1, 0,0,8'hFE,0);
        // priority: reset start first (FC), then pending NMI (FA), then FE
        r(0,1,1,0,1, 0,1,8'hFC,0);
        r(0,1,1,0,1, 0,1,8'hFC,0);
        r(1,1,1,0,1, 0,1,8'hFC,1);
        r(1,1,1,0,1, 0,1,8'hFC,1);
        r(1,1,1,0,1, 0,1,8'hFC,1);
        r(1,1,0,0,1, 0,1,8'hFC,1);
        r(1,1,0,0,1, 0,1,8'hFC,1);
        r(1,1,0,0,1, 0,1,8'hFC,1);
        r(1,1,0,1,1, 0,1,8'hFC,1);
        r(1,1,0,0,1, 0,1,8'hFC,1);
        r(1,1,0,1,1, 0,0,8'hFA,1);
        r(1,1,0,1,1, 0,0,8'hFE,0);
        // mid-operation reset discards pending NMI; held-low pin makes no edge
        r(1,1,1,0,1, 0,0,8'hFE,0);
        r(1,1,1,0,1, 0,0,8'hFE,0);
        r(1,1,1,0,1, 0,0,8'hFE,0);
        r(1,1,0,0,1, 0,0,8'hFE,0);
        r(1,1,0,0,1, 0,0,8'hFE,0);
        r(1,1,0,0,1, 0,1,8'hFE,0);
        r(0,1,0,0,1, 0,1,8'hFC,0);
        r(1,1,0,1,1, 0,0,8'hFC,1);
        r(1,1,0,0,1, 0,0,8'hFC,0);
        r(1,1,0,1,1, 0,0,8'hFE,0);
        r(1,1,0,0,1, 0,0,8'hFE,0);
        r(1,1,0,1,1, 0,0,8'hFE,0);
        r(1,1,0,0,1, 0,0,8'hFE,0);
        r(1,1,0,1,1, 0,0,8'hFE,0);

        for (int k = 0; k < tbl.size(); k++) begin
            cur = tbl[k];
            @(negedge clk);
            reset = cur.rs; IRQ_n = cur.irq_n; NMI_n = cur.nmi_n;
            sync = cur.sy; I = cur.i;
            exp_q.push_back(cur);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard row %0d: queue empty", k);
            end else begin
                e = exp_q.pop_front();
                chk1("irq",    e.id, {7'd0, irq},  {7'd0, e.e_irq});
                chk1("nmi",    e.id, {7'd0, nmi},  {7'd0, e.e_nmi});
                chk1("vector", e.id, vector,       e.e_vec);
                chk1("wake",   e.id, {7'd0, wake}, {7'd0, e.e_wake});
            end
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d left expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
